// File: rtl/keypad_if.sv
// Keypad scanner bundle: row drive and column sense toward the matrix,
// debounced key level and key pulse toward the graphics stage.
interface keypad_if;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic [4:0] key;
    logic [4:0] key_pulse;

    modport master (
        input  key_col,
        output key_row,
        output key,
        output key_pulse
    );

    modport slave (
        output key_col,
        input  key_row,
        input  key,
        input  key_pulse
    );
endinterface : keypad_if

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one-hot row drive, lowest-code priority resolve,
// and a scan-rate debouncer producing a level key and a one-clock key pulse.
module keypad_scan #(
    parameter int SCAN_DIV  = 25000,
    parameter int DEB_SCANS = 4
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEB_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        HELD
    } deb_state_e;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       key_row_q, key_row_d;
    logic [4:0]       acc_q, acc_d;
    logic [4:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       key_q, key_d;
    logic [4:0]       pulse_q, pulse_d;
    deb_state_e       state_q, state_d;

    logic       tick;
    logic       scan_end;
    logic       col_hit;
    logic [1:0] col_idx;
    logic [4:0] scan_result;

    assign tick     = (div_q == DIV_LAST);
    assign scan_end = tick && (row_q == 2'd3);
    assign col_hit  = |kp.key_col;

    // Lowest set column wins; scanning from the top leaves the smallest index.
    always_comb begin
        col_idx = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (kp.key_col[c]) col_idx = 2'(c);
        end
    end

    // The first hit of a scan is kept; later rows only fill an empty accumulator.
    assign scan_result = (tick && !acc_q[4] && col_hit) ? {1'b1, row_q, col_idx} : acc_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        div_d     = div_q + DIV_W'(1);
        row_d     = row_q;
        key_row_d = key_row_q;
        acc_d     = acc_q;
        if (tick) begin
            div_d     = '0;
            row_d     = row_q + 2'd1;
            key_row_d = 4'b0001 << row_d;
            acc_d     = scan_end ? 5'h00 : scan_result;
        end
    end

    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        pulse_d = 5'h00;
        state_d = state_q;
        if (scan_end) begin
            if (scan_result == cand_q) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            end else begin
                cand_d = scan_result;
                cnt_d  = CNT_ONE;
            end

            if ((cnt_d == CNT_MAX) && (cand_d != key_q)) begin
                case (state_q)
                    IDLE: begin
                        key_d   = cand_d;
                        pulse_d = cand_d;
                        state_d = HELD;
                    end
                    HELD: begin
                        key_d = cand_d;
                        if (cand_d == 5'h00) begin
                            state_d = IDLE;
                        end else begin
                            pulse_d = cand_d;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            row_q     <= 2'd0;
            key_row_q <= 4'b0001;
            acc_q     <= 5'h00;
        end else begin
            div_q     <= div_d;
            row_q     <= row_d;
            key_row_q <= key_row_d;
            acc_q     <= acc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= 5'h00;
            cnt_q   <= '0;
            key_q   <= 5'h00;
            pulse_q <= 5'h00;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            pulse_q <= pulse_d;
        end
    end

    assign kp.key_row   = key_row_q;
    assign kp.key       = key_q;
    assign kp.key_pulse = pulse_q;

endmodule : keypad_scan

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a 16-key press mask drives the columns from the row
// drive; a scan-level model of resolve and debounce predicts key and key_pulse.
module tb_keypad_scan;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 3;
    localparam int SCAN_CLKS = 4 * SCAN_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] mask = 16'h0000;

    int checks = 0;
    int errors = 0;

    logic [4:0] m_cand = 5'h00;
    int         m_cnt  = 0;
    logic [4:0] m_key  = 5'h00;

    keypad_if kif ();

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DEB_SCANS(DEB_SCANS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kif)
    );

    always #5 clk = ~clk;

    // The matrix: a pressed key connects its row line to its column line.
    always_comb begin
        kif.key_col = 4'h0;
        case (kif.key_row)
            4'b0001: kif.key_col = mask[3:0];
            4'b0010: kif.key_col = mask[7:4];
            4'b0100: kif.key_col = mask[11:8];
            4'b1000: kif.key_col = mask[15:12];
            default: kif.key_col = 4'h0;
        endcase
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] resolve(input logic [15:0] m);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) return {1'b1, 4'(i)};
        end
        return 5'h00;
    endfunction

    // One complete scan of a steady press mask, as seen by the debouncer.
    task automatic model_scan(input logic [15:0] m, output logic [4:0] exp_pulse);
        logic [4:0] r;
        r = resolve(m);
        if (r == m_cand) begin
            m_cnt = (m_cnt < DEB_SCANS) ? m_cnt + 1 : DEB_SCANS;
        end else begin
            m_cand = r;
            m_cnt  = 1;
        end
        exp_pulse = 5'h00;
        if (m_cnt == DEB_SCANS && m_cand != m_key) begin
            exp_pulse = m_cand;
            m_key     = m_cand;
        end
    endtask

    // Called with the next posedge being the first clock of a scan.
    task automatic run_scan(input logic [15:0] m);
        logic [4:0] exp_pulse;
        mask = m;
        for (int i = 1; i <= SCAN_CLKS; i++) begin
            @(posedge clk);
            #1;
            check("key_row", 16'(kif.key_row), 16'(4'b0001 << ((i / SCAN_DIV) % 4)));
            if (i < SCAN_CLKS) begin
                check("key_hold", 16'(kif.key), 16'(m_key));
                check("pulse_idle", 16'(kif.key_pulse), 16'h0000);
            end else begin
                model_scan(m, exp_pulse);
                check("key_scan_end", 16'(kif.key), 16'(m_key));
                check("pulse_scan_end", 16'(kif.key_pulse), 16'(exp_pulse));
            end
        end
    endtask

    task automatic run_scans(input logic [15:0] m, input int n);
        for (int s = 0; s < n; s++) run_scan(m);
    endtask

    // Reset k clocks into a scan; afterwards the next posedge starts a fresh scan.
    task automatic reset_mid(input int k);
        repeat (k) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_key_row", 16'(kif.key_row), 16'h0001);
        check("rst_key", 16'(kif.key), 16'h0000);
        check("rst_pulse", 16'(kif.key_pulse), 16'h0000);
        m_cand = 5'h00;
        m_cnt  = 0;
        m_key  = 5'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] random_mask();
        logic [15:0] m;
        case ($urandom_range(0, 4))
            0: m = 16'h0000;
            1: m = 16'h0001 << $urandom_range(0, 15);
            2: m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            3: m = 16'h0002;
            default: m = 16'($urandom());
        endcase
        return m;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("init_key_row", 16'(kif.key_row), 16'h0001);
        check("init_key", 16'(kif.key), 16'h0000);
        check("init_pulse", 16'(kif.key_pulse), 16'h0000);
        rst = 1'b0;

        // Press row0/col1 and hold; key appears after the third scan.
        run_scans(16'h0002, 5);
        check("press_key", 16'(kif.key), 16'h0011);

        // Reset while the key is held.
        reset_mid(7);
        run_scans(16'h0000, 2);

        // Bounce: press on alternate scans never settles.
        for (int s = 0; s < 12; s++) run_scan((s % 2 == 0) ? 16'h0002 : 16'h0000);
        check("bounce_key", 16'(kif.key), 16'h0000);

        // Priority: row0/col3 beats row1/col1.
        run_scans(16'h0028, 4);
        check("prio_key", 16'(kif.key), 16'h0013);

        // Direct changes then release.
        run_scans(16'h0002, 4);
        run_scans(16'h0020, 4);
        check("change_key", 16'(kif.key), 16'h0015);
        run_scans(16'h0000, 4);
        check("release_key", 16'(kif.key), 16'h0000);

        // Reset mid-debounce discards the two stable scans already seen.
        run_scans(16'h0002, 2);
        reset_mid($urandom_range(0, SCAN_CLKS - 1));
        run_scans(16'h0002, 2);
        check("redeb_wait", 16'(kif.key), 16'h0000);
        run_scan(16'h0002);
        check("redeb_key", 16'(kif.key), 16'h0011);

        // Random press patterns with random hold lengths and occasional resets.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) reset_mid($urandom_range(0, SCAN_CLKS - 1));
            run_scans(random_mask(), $urandom_range(1, 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_keypad_scan
